// File: rtl/cpu_pkg.sv
// Shared CPU-core constants: sequencing modes, stage indices and the
// legacy one-hot stage codes used by the fixed five-stage core.
package cpu_pkg;

  // Sequencing modes selected by stage_sequencer.PIPELINED
  localparam int MODE_MULTI = 0;
  localparam int MODE_PIPE  = 1;

  // Fetch is always stage 0; writeback index shown for the classic 5-stage core
  localparam int STAGE_FETCH = 0;
  localparam int STAGE_WBK   = 4;

  // One-hot stage codes kept for existing 5-stage users
  localparam logic [4:0] ST_IF  = 5'b00001;
  localparam logic [4:0] ST_ID  = 5'b00010;
  localparam logic [4:0] ST_EX  = 5'b00100;
  localparam logic [4:0] ST_MEM = 5'b01000;
  localparam logic [4:0] ST_WB  = 5'b10000;

  // Writeback index for an arbitrary stage count
  function automatic int wbk_index(input int num_stages);
    return num_stages - 1;
  endfunction

endpackage

// File: rtl/event_counter.sv
// Free-running wrapping event counter with synchronous reset and an
// increment enable.
module event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: add one when the event fires, wrapping naturally at 2^CNT_W
  always_comb begin
    count_d = count_q + CNT_W'(inc_i);
  end

  // Count register with synchronous reset
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// N-stage CPU stage controller: multi-cycle one-hot rotation or an
// overlapped pipeline with backpressure, plus flush, halt/drain and
// retire/stall event counters. stage_advance drives the datapath's
// inter-stage register load enables.
module stage_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int PIPELINED  = MODE_MULTI,
  parameter int CNT_W      = 32
) (
  input  logic                  sysclk,
  input  logic                  cpu_reset,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic                  flush,
  input  logic                  halt,
  output logic [NUM_STAGES-1:0] stage_active,
  output logic [NUM_STAGES-1:0] stage_advance,
  output logic                  retire,
  output logic                  busy,
  output logic [CNT_W-1:0]      retire_count,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int                    LAST       = wbk_index(NUM_STAGES);
  localparam logic [NUM_STAGES-1:0] FETCH_ONLY = NUM_STAGES'(1) << STAGE_FETCH;

  logic [NUM_STAGES-1:0] stage_active_q;
  logic [NUM_STAGES-1:0] stage_active_d;
  logic                  stall_event;

  // Advance chain, built from writeback back toward fetch so each stage
  // can see whether its successor is free or moving on this cycle.
  for (genvar j = 0; j < NUM_STAGES; j++) begin : g_adv
    localparam int S = LAST - j;
    logic go;
    logic adv;
    if (j == 0) begin : g_wbk
      // Writeback never waits on anything downstream and survives flush
      assign go = 1'b1;
    end else if (PIPELINED == MODE_PIPE) begin : g_pipe
      assign go = ~flush & (~stage_active_q[S+1] | g_adv[j-1].adv);
    end else begin : g_multi
      assign go = ~flush;
    end
    assign adv              = stage_active_q[S] & stage_ready[S] & go;
    assign stage_advance[S] = adv;
  end

  // Next-state for the active vector in the selected mode
  always_comb begin
    // NOTE: default assigned first so no path leaves stage_active_d unassigned (no latch).
    stage_active_d = '0;
    if (PIPELINED == MODE_PIPE) begin
      // Fetch refills when empty or advancing unless halted
      stage_active_d[STAGE_FETCH] = halt ? (stage_active_q[STAGE_FETCH] & ~stage_advance[STAGE_FETCH])
                                         : 1'b1;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_active_d[i] = stage_advance[i-1] | (stage_active_q[i] & ~stage_advance[i]);
      end
      if (flush) begin
        for (int i = 1; i < LAST; i++) begin
          stage_active_d[i] = 1'b0;
        end
        stage_active_d[STAGE_FETCH] = ~halt;
      end
    end else begin
      if (stage_active_q == '0 || (flush && !stage_active_q[LAST])) begin
        // Idle, or flushed without writeback in flight: restart at fetch
        stage_active_d[STAGE_FETCH] = ~halt;
      end else begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (stage_active_q[i]) begin
            if (!stage_advance[i]) begin
              stage_active_d[i] = 1'b1;
            end else if (i == LAST) begin
              stage_active_d[STAGE_FETCH] = ~halt;
            end else begin
              stage_active_d[(i + 1) % NUM_STAGES] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Active-vector register; reset parks a single token in fetch
  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      stage_active_q <= FETCH_ONLY;
    end else begin
      stage_active_q <= stage_active_d;
    end
  end

  // A stall cycle is any active stage not ready, flush cycles excluded
  assign stall_event = ~flush & (|(stage_active_q & ~stage_ready));

  assign stage_active = stage_active_q;
  assign retire       = stage_advance[LAST];
  assign busy         = |stage_active_q;

  event_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk_i   (sysclk),
    .rst_i   (cpu_reset),
    .inc_i   (retire),
    .count_o (retire_count)
  );

  event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (sysclk),
    .rst_i   (cpu_reset),
    .inc_i   (stall_event),
    .count_o (stall_count)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench: six stage_sequencer configurations (N=5/2/8, both
// modes) share stimulus and are compared every cycle against a token-level
// reference model, plus directed absolute checks from the timing scenarios.
module tb_stage_sequencer;

  localparam int         NI  = 6;
  localparam logic [7:0] ALL = 8'hFF;

  logic       sysclk = 1'b0;
  logic       cpu_reset = 1'b1;
  logic       flush = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] rdy = 8'hFF;

  int total = 0;
  int bad   = 0;

  always #5 sysclk = ~sysclk;

  logic [4:0]  a0, v0, a1, v1;
  logic [1:0]  a2, v2, a3, v3;
  logic [7:0]  a4, v4, a5, v5;
  logic        r0, r1, r2, r3, r4, r5;
  logic        b0, b1, b2, b3, b4, b5;
  logic [31:0] rc0, sc0, rc1, sc1, rc4, sc4, rc5, sc5;
  logic [3:0]  rc2, sc2, rc3, sc3;

  stage_sequencer #(.NUM_STAGES(5), .PIPELINED(0), .CNT_W(32)) u0 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .stage_ready(rdy[4:0]), .flush(flush), .halt(halt),
    .stage_active(a0), .stage_advance(v0), .retire(r0), .busy(b0),
    .retire_count(rc0), .stall_count(sc0));
  stage_sequencer #(.NUM_STAGES(5), .PIPELINED(1), .CNT_W(32)) u1 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .stage_ready(rdy[4:0]), .flush(flush), .halt(halt),
    .stage_active(a1), .stage_advance(v1), .retire(r1), .busy(b1),
    .retire_count(rc1), .stall_count(sc1));
  stage_sequencer #(.NUM_STAGES(2), .PIPELINED(0), .CNT_W(4)) u2 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .stage_ready(rdy[1:0]), .flush(flush), .halt(halt),
    .stage_active(a2), .stage_advance(v2), .retire(r2), .busy(b2),
    .retire_count(rc2), .stall_count(sc2));
  stage_sequencer #(.NUM_STAGES(2), .PIPELINED(1), .CNT_W(4)) u3 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .stage_ready(rdy[1:0]), .flush(flush), .halt(halt),
    .stage_active(a3), .stage_advance(v3), .retire(r3), .busy(b3),
    .retire_count(rc3), .stall_count(sc3));
  stage_sequencer #(.NUM_STAGES(8), .PIPELINED(0), .CNT_W(32)) u4 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .stage_ready(rdy[7:0]), .flush(flush), .halt(halt),
    .stage_active(a4), .stage_advance(v4), .retire(r4), .busy(b4),
    .retire_count(rc4), .stall_count(sc4));
  stage_sequencer #(.NUM_STAGES(8), .PIPELINED(1), .CNT_W(32)) u5 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .stage_ready(rdy[7:0]), .flush(flush), .halt(halt),
    .stage_active(a5), .stage_advance(v5), .retire(r5), .busy(b5),
    .retire_count(rc5), .stall_count(sc5));

  // Uniform 8-bit / 32-bit views of every instance
  logic [7:0]  o_act  [NI];
  logic [7:0]  o_adv  [NI];
  logic        o_ret  [NI];
  logic        o_busy [NI];
  logic [31:0] o_rc   [NI];
  logic [31:0] o_sc   [NI];

  assign o_act[0] = {3'b0, a0}; assign o_adv[0] = {3'b0, v0};
  assign o_act[1] = {3'b0, a1}; assign o_adv[1] = {3'b0, v1};
  assign o_act[2] = {6'b0, a2}; assign o_adv[2] = {6'b0, v2};
  assign o_act[3] = {6'b0, a3}; assign o_adv[3] = {6'b0, v3};
  assign o_act[4] = a4;         assign o_adv[4] = v4;
  assign o_act[5] = a5;         assign o_adv[5] = v5;
  assign o_ret[0] = r0; assign o_ret[1] = r1; assign o_ret[2] = r2;
  assign o_ret[3] = r3; assign o_ret[4] = r4; assign o_ret[5] = r5;
  assign o_busy[0] = b0; assign o_busy[1] = b1; assign o_busy[2] = b2;
  assign o_busy[3] = b3; assign o_busy[4] = b4; assign o_busy[5] = b5;
  assign o_rc[0] = rc0; assign o_sc[0] = sc0;
  assign o_rc[1] = rc1; assign o_sc[1] = sc1;
  assign o_rc[2] = {28'b0, rc2}; assign o_sc[2] = {28'b0, sc2};
  assign o_rc[3] = {28'b0, rc3}; assign o_sc[3] = {28'b0, sc3};
  assign o_rc[4] = rc4; assign o_sc[4] = sc4;
  assign o_rc[5] = rc5; assign o_sc[5] = sc5;

  function automatic int cfg_n(input int k);
    case (k)
      0, 1:    return 5;
      2, 3:    return 2;
      default: return 8;
    endcase
  endfunction

  function automatic bit cfg_pipe(input int k);
    return (k % 2) == 1;
  endfunction

  function automatic int cfg_w(input int k);
    return (k == 2 || k == 3) ? 4 : 32;
  endfunction

  // Reference model: multi-cycle keeps the token position (-1 = idle),
  // pipelined keeps a per-stage occupancy map moved token by token.
  int         pos_m [NI];
  logic [8:0] occ_m [NI];
  longint     rc_m  [NI];
  longint     sc_m  [NI];
  bit         valid_m = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    int         n;
    bit         pipe;
    longint     mask;
    logic [8:0] occ;
    logic [8:0] adv;
    logic [8:0] nocc;
    bit         stall;
    n    = cfg_n(k);
    pipe = cfg_pipe(k);
    mask = (longint'(1) << cfg_w(k)) - 1;
    occ  = pipe ? occ_m[k] : ((pos_m[k] < 0) ? 9'd0 : (9'd1 << pos_m[k]));

    // Which tokens move this cycle
    adv = '0;
    if (!pipe) begin
      if (pos_m[k] >= 0)
        adv[pos_m[k]] = rdy[pos_m[k]] && (pos_m[k] == n - 1 || !flush);
    end else begin
      for (int i = n - 1; i >= 0; i--) begin
        if (occ[i] && rdy[i] && (i == n - 1 || (!flush && (!occ[i+1] || adv[i+1]))))
          adv[i] = 1'b1;
      end
    end
    stall = 1'b0;
    for (int i = 0; i < n; i++)
      if (occ[i] && !rdy[i]) stall = 1'b1;
    if (flush) stall = 1'b0;

    if (valid_m) begin
      check($sformatf("cfg%0d_active", k), 64'(o_act[k]), 64'(occ[7:0]));
      check($sformatf("cfg%0d_advance", k), 64'(o_adv[k]), 64'(adv[7:0]));
      check($sformatf("cfg%0d_retire", k), 64'(o_ret[k]), 64'(adv[n-1]));
      check($sformatf("cfg%0d_busy", k), 64'(o_busy[k]), 64'(|occ));
      check($sformatf("cfg%0d_retire_count", k), 64'(o_rc[k]), 64'(rc_m[k]));
      check($sformatf("cfg%0d_stall_count", k), 64'(o_sc[k]), 64'(sc_m[k]));
    end

    if (cpu_reset) begin
      pos_m[k] = 0;
      occ_m[k] = 9'd1;
      rc_m[k]  = 0;
      sc_m[k]  = 0;
    end else begin
      rc_m[k] = (rc_m[k] + longint'(adv[n-1])) & mask;
      sc_m[k] = (sc_m[k] + longint'(stall)) & mask;
      if (!pipe) begin
        if (pos_m[k] < 0 || (flush && pos_m[k] != n - 1))
          pos_m[k] = halt ? -1 : 0;
        else if (adv[pos_m[k]])
          pos_m[k] = (pos_m[k] == n - 1) ? (halt ? -1 : 0) : pos_m[k] + 1;
      end else begin
        nocc = '0;
        for (int i = 0; i < n; i++) begin
          if (occ[i]) begin
            if (!adv[i]) nocc[i] = 1'b1;
            else if (i < n - 1) nocc[i+1] = 1'b1;
          end
        end
        if (flush)
          for (int i = 0; i < n - 1; i++) nocc[i] = 1'b0;
        if (!nocc[0] && !halt) nocc[0] = 1'b1;
        occ_m[k] = nocc;
      end
    end
  endtask

  // One clock: drive inputs after the edge, sample at the falling edge
  task automatic step(input bit rst, input logic [7:0] r, input bit fl, input bit hl);
    @(posedge sysclk);
    #1;
    cpu_reset = rst;
    rdy       = r;
    flush     = fl;
    halt      = hl;
    @(negedge sysclk);
    for (int k = 0; k < NI; k++) model_step(k);
    valid_m = 1'b1;
  endtask

  bit hl_r;

  initial begin
    // Rotation / fill with everything ready (cycle c = c-th cycle after reset)
    step(1'b1, ALL, 1'b0, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      step(1'b0, ALL, 1'b0, 1'b0);
      if (c == 4) check("multi_retire_c4", 64'(o_ret[0]), 64'd1);
      if (c == 4) check("pipe_first_retire_c4", 64'(o_ret[1]), 64'd1);
      if (c == 3) check("multi_active_c3", 64'(o_act[0]), 64'h08);
    end
    check("multi5_retire_count_c20", 64'(o_rc[0]), 64'd4);
    check("pipe5_retire_count_c20", 64'(o_rc[1]), 64'd16);
    check("multi2_retire_count_c20", 64'(o_rc[2]), 64'd10);
    check("pipe2_retire_count_wrap", 64'(o_rc[3]), 64'd3);
    check("multi8_retire_count_c20", 64'(o_rc[4]), 64'd2);
    check("pipe8_retire_count_c20", 64'(o_rc[5]), 64'd13);

    // Stall on stage 3 for cycles 6..8
    step(1'b1, ALL, 1'b0, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      step(1'b0, (c >= 6 && c <= 8) ? 8'hF7 : ALL, 1'b0, 1'b0);
      if (c == 7) check("stall_active_c7", 64'(o_act[1]), 64'h0F);
    end
    check("stall_count_after", 64'(o_sc[1]), 64'd3);

    // Flush at cycle 6 in pipelined steady state
    step(1'b1, ALL, 1'b0, 1'b0);
    for (int c = 0; c <= 10; c++) begin
      step(1'b0, ALL, c == 6, 1'b0);
      if (c == 6) check("flush_retire_c6", 64'(o_ret[1]), 64'd1);
      if (c == 7) check("flush_active_c7", 64'(o_act[1]), 64'h01);
    end

    // Halt drain: halt over cycles 10..16
    step(1'b1, ALL, 1'b0, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      step(1'b0, ALL, 1'b0, c >= 10 && c <= 16);
      if (c == 14) check("halt_busy_c14", 64'(o_busy[1]), 64'd1);
      if (c == 15) check("halt_busy_c15", 64'(o_busy[1]), 64'd0);
      if (c == 18) check("halt_restart_c18", 64'(o_act[1]), 64'h01);
    end

    // Reset mid-stall at cycle 8, then flush+halt together at cycle 9
    step(1'b1, ALL, 1'b0, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      step(c == 8, (c >= 6) ? 8'hF7 : ALL, c == 9, c == 9);
      if (c == 9) begin
        check("rst_mid_active", 64'(o_act[1]), 64'h01);
        check("rst_mid_retire_count", 64'(o_rc[1]), 64'd0);
        check("rst_mid_stall_count", 64'(o_sc[1]), 64'd0);
      end
      if (c == 10) begin
        check("flush_halt_multi_idle", 64'(o_act[0]), 64'h00);
        check("flush_halt_pipe_idle", 64'(o_act[1]), 64'h00);
      end
      if (c == 11) check("idle_restart_multi", 64'(o_act[0]), 64'h01);
    end

    // Randomised traffic against the model
    step(1'b1, ALL, 1'b0, 1'b0);
    hl_r = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) hl_r = ~hl_r;
      step($urandom_range(0, 63) == 0, 8'($urandom | $urandom),
           $urandom_range(0, 15) == 0, hl_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
